// File: rtl/sys_bus_arbiter_if.sv
// Bundle of the per-core request ports and the shared system-bus port of sys_bus_arbiter.
// The arbiter uses the master modport; the cores and the bus slave side use the slave modport.
interface sys_bus_arbiter_if #(
    parameter int NUM_MASTERS = 4
);
    localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    logic [32*NUM_MASTERS-1:0] s_addr;
    logic [32*NUM_MASTERS-1:0] s_wdata;
    logic [4*NUM_MASTERS-1:0]  s_be;
    logic [NUM_MASTERS-1:0]    s_we;
    logic [NUM_MASTERS-1:0]    s_req;
    logic [32*NUM_MASTERS-1:0] s_rdata;
    logic [NUM_MASTERS-1:0]    s_ready;
    logic [NUM_MASTERS-1:0]    s_err;

    logic [31:0]               m_addr;
    logic [31:0]               m_wdata;
    logic [3:0]                m_be;
    logic                      m_we;
    logic                      m_req;
    logic [31:0]               m_rdata;
    logic                      m_ready;

    logic [GW-1:0]             grant_id;
    logic                      busy;

    modport master (
        input  s_addr, s_wdata, s_be, s_we, s_req,
        output s_rdata, s_ready, s_err,
        output m_addr, m_wdata, m_be, m_we, m_req,
        input  m_rdata, m_ready,
        output grant_id, busy
    );

    modport slave (
        output s_addr, s_wdata, s_be, s_we, s_req,
        input  s_rdata, s_ready, s_err,
        input  m_addr, m_wdata, m_be, m_we, m_req,
        output m_rdata, m_ready,
        input  grant_id, busy
    );
endinterface

// File: rtl/sys_bus_arbiter.sv
// Round-robin arbiter sharing one system-bus master port among NUM_MASTERS core ports,
// with a registered transaction, same-cycle response routing and an optional response timeout.
module sys_bus_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int TIMEOUT_CYCLES = 0
) (
    input logic               clk,
    input logic               rst_n,
    sys_bus_arbiter_if.master bus
);
    localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    if (NUM_MASTERS < 2 || NUM_MASTERS > 8) begin : g_bad_n
        $error("sys_bus_arbiter: NUM_MASTERS must be 2..8");
    end
    if (TIMEOUT_CYCLES < 0 || TIMEOUT_CYCLES > 65535) begin : g_bad_to
        $error("sys_bus_arbiter: TIMEOUT_CYCLES must be 0..65535");
    end

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [GW-1:0] last_q, last_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    be_q, be_d;
    logic          we_q, we_d;

    logic          win_vld;
    logic [GW-1:0] win_id;
    logic [31:0]   sel_addr, sel_wdata;
    logic [3:0]    sel_be;
    logic          sel_we;
    logic          to_hit;
    logic          done;

    function automatic logic [GW-1:0] rr_idx(input logic [GW-1:0] base, input int k);
        int s;
        s = (int'(base) + k) % NUM_MASTERS;
        return GW'(s);
    endfunction

    // Scan from the farthest offset down so the nearest requester after last_q wins.
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            if (bus.s_req[rr_idx(last_q, k)]) begin
                win_vld = 1'b1;
                win_id  = rr_idx(last_q, k);
            end
        end
    end

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_be    = '0;
        sel_we    = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (win_id == GW'(i)) begin
                sel_addr  = bus.s_addr[32*i +: 32];
                sel_wdata = bus.s_wdata[32*i +: 32];
                sel_be    = bus.s_be[4*i +: 4];
                sel_we    = bus.s_we[i];
            end
        end
    end

    if (TIMEOUT_CYCLES > 0) begin : g_to
        logic [15:0] cnt_q, cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (state_q == IDLE) begin
                cnt_d = '0;
            end else if (cnt_q != 16'hFFFF) begin
                cnt_d = cnt_q + 16'd1;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign to_hit = (state_q == BUSY) && !bus.m_ready
                        && (cnt_q == 16'(TIMEOUT_CYCLES));
    end else begin : g_no_to
        assign to_hit = 1'b0;
    end

    assign done = (state_q == BUSY) && (bus.m_ready || to_hit);

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        grant_d = grant_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        we_d    = we_q;
        unique case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d = BUSY;
                    grant_d = win_id;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    be_d    = sel_be;
                    we_d    = sel_we;
                end
            end
            BUSY: begin
                if (done) begin
                    state_d = IDLE;
                    last_d  = grant_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= GW'(NUM_MASTERS - 1);
            grant_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            we_q    <= we_d;
        end
    end

    assign bus.m_req    = (state_q == BUSY);
    assign bus.busy     = (state_q == BUSY);
    assign bus.grant_id = grant_q;
    assign bus.m_addr   = addr_q;
    assign bus.m_wdata  = wdata_q;
    assign bus.m_be     = be_q;
    assign bus.m_we     = we_q;

    // A timeout completion returns zero data with the error flag; a real response wins.
    always_comb begin
        bus.s_ready = '0;
        bus.s_err   = '0;
        bus.s_rdata = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (done && grant_q == GW'(i)) begin
                bus.s_ready[i]          = 1'b1;
                bus.s_err[i]            = !bus.m_ready;
                bus.s_rdata[32*i +: 32] = bus.m_ready ? bus.m_rdata : 32'h0;
            end
        end
    end
endmodule

// File: tb/tb_sys_bus_arbiter.sv
// Randomized scoreboard bench for sys_bus_arbiter: a round-robin reference model predicts
// bus payloads, a behavioural slave predicts responses, and a monitor checks the core ports.
module tb_sys_bus_arbiter;
    localparam int N  = 4;
    localparam int TO = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sys_bus_arbiter_if #(.NUM_MASTERS(N)) bus ();

    sys_bus_arbiter #(
        .NUM_MASTERS   (N),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct packed {
        logic [1:0]  own;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        we;
    } bus_t;

    typedef struct packed {
        logic [1:0]  own;
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    bus_t bus_q[$];
    rsp_t rsp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // reference model state
    bit   mb    = 1'b0;
    int   mown  = 0;
    int   mlast = N - 1;
    int   mcnt  = 0;

    // stimulus / slave state
    bit   pend[N];
    bit   done[N];
    int   req_pct  = 0;
    int   lat_max  = 0;
    bit   gapchk   = 1'b0;
    int   cyc      = 0;
    int   last_cmp = 0;
    bit   sl_act   = 1'b0;
    int   sl_cyc   = 0;
    int   sl_lat   = 0;
    bus_t cur;

    function automatic int rr_pick(input int last, input logic [N-1:0] req);
        int w;
        w = -1;
        for (int k = 1; k <= N; k++) begin
            if (w < 0 && req[(last + k) % N]) w = (last + k) % N;
        end
        return w;
    endfunction

    function automatic bus_t mk_exp(input int o);
        bus_t e;
        e.own   = 2'(o);
        e.addr  = bus.s_addr[32*o +: 32];
        e.wdata = bus.s_wdata[32*o +: 32];
        e.be    = bus.s_be[4*o +: 4];
        e.we    = bus.s_we[o];
        return e;
    endfunction

    // Round-robin reference: winner is the first requester after the last owner.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mb    <= 1'b0;
            mown  <= 0;
            mlast <= N - 1;
            mcnt  <= 0;
            bus_q.delete();
        end else if (mb) begin
            if (bus.m_ready || mcnt == TO) begin
                mlast <= mown;
                mb    <= 1'b0;
            end else begin
                mcnt <= mcnt + 1;
            end
        end else if (bus.s_req != '0) begin
            mb   <= 1'b1;
            mcnt <= 0;
            mown <= rr_pick(mlast, bus.s_req);
            bus_q.push_back(mk_exp(rr_pick(mlast, bus.s_req)));
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        bit   exp_done;
        rsp_t r;
        @(negedge clk);
        cyc++;
        exp_done = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (done[i]) begin
                pend[i]      = 1'b0;
                done[i]      = 1'b0;
                bus.s_req[i] = 1'b0;
            end
            if (!pend[i]) begin
                if ($urandom_range(99) < 32'(req_pct)) begin
                    pend[i]                  = 1'b1;
                    bus.s_req[i]             = 1'b1;
                    bus.s_addr[32*i +: 32]   = $urandom;
                    bus.s_wdata[32*i +: 32]  = $urandom;
                    bus.s_be[4*i +: 4]       = 4'($urandom);
                    bus.s_we[i]              = 1'($urandom);
                end
            end else if (mb && mown == i && $urandom_range(3) == 0) begin
                bus.s_addr[32*i +: 32]  = $urandom;
                bus.s_wdata[32*i +: 32] = $urandom;
                bus.s_be[4*i +: 4]      = 4'($urandom);
                bus.s_we[i]             = 1'($urandom);
                if ($urandom_range(3) == 0) bus.s_req[i] = 1'b0;
            end
        end
        // behavioural slave: random latency, a latency beyond TO never answers
        bus.m_ready = 1'b0;
        bus.m_rdata = $urandom;
        if (bus.m_req) begin
            if (!sl_act) begin
                chk("grant_expected", 128'(bus_q.size() != 0), 128'(1));
                if (bus_q.size() != 0) cur = bus_q.pop_front();
                sl_act = 1'b1;
                sl_cyc = 0;
                sl_lat = int'($urandom_range(lat_max));
            end
            chk("bus_payload", 128'({bus.grant_id, bus.m_addr, bus.m_wdata, bus.m_be, bus.m_we}),
                128'(cur));
            if (sl_lat <= TO && sl_cyc == sl_lat) begin
                bus.m_ready = 1'b1;
                rsp_q.push_back({cur.own, 1'b0, bus.m_rdata});
                exp_done = 1'b1;
                sl_act   = 1'b0;
            end else if (sl_cyc == TO) begin
                rsp_q.push_back({cur.own, 1'b1, 32'h0});
                exp_done = 1'b1;
                sl_act   = 1'b0;
            end
            sl_cyc++;
        end
        #1;
        chk("m_req_vs_model", 128'(bus.m_req), 128'(mb));
        chk("busy_vs_model", 128'(bus.busy), 128'(mb));
        if (exp_done || bus.s_ready != '0) begin
            chk("ready_when_expected", 128'(bus.s_ready != '0), 128'(exp_done));
            if (rsp_q.size() == 0) begin
                chk("rsp_queue_nonempty", 128'(0), 128'(1));
            end else begin
                r = rsp_q.pop_front();
                chk("s_ready", 128'(bus.s_ready), 128'(4'b0001 << r.own));
                chk("s_err", 128'(bus.s_err), r.err ? 128'(4'b0001 << r.own) : 128'(0));
                chk("s_rdata", 128'(bus.s_rdata), 128'(r.rdata) << (32 * int'(r.own)));
                done[r.own] = 1'b1;
                if (gapchk && last_cmp > 0) chk("completion_gap", 128'(cyc - last_cmp), 128'(2));
                last_cmp = cyc;
            end
        end else begin
            chk("idle_s_outputs", {bus.s_err, bus.s_rdata[123:0]}, 128'(0));
        end
    endtask

    task automatic clear_engine();
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0;
            done[i] = 1'b0;
        end
        bus.s_req   = '0;
        bus.m_ready = 1'b0;
        sl_act      = 1'b0;
        rsp_q.delete();
    endtask

    initial begin
        bit found;
        bus.s_req   = '0;
        bus.s_addr  = '0;
        bus.s_wdata = '0;
        bus.s_be    = '0;
        bus.s_we    = '0;
        bus.m_ready = 1'b0;
        bus.m_rdata = '0;
        clear_engine();

        // reset defaults with random inputs
        repeat (3) begin
            @(negedge clk);
            bus.s_req   = 4'($urandom);
            bus.s_addr  = {$urandom, $urandom, $urandom, $urandom};
            bus.s_we    = 4'($urandom);
            bus.s_be    = 16'($urandom);
            bus.m_ready = 1'($urandom);
            bus.m_rdata = $urandom;
            #1;
            chk("rst_m_req", 128'(bus.m_req), 128'(0));
            chk("rst_busy", 128'(bus.busy), 128'(0));
            chk("rst_grant_id", 128'(bus.grant_id), 128'(0));
            chk("rst_m_payload", 128'({bus.m_addr, bus.m_wdata, bus.m_be, bus.m_we}), 128'(0));
            chk("rst_s_ready_err", 128'({bus.s_ready, bus.s_err}), 128'(0));
            chk("rst_s_rdata", 128'(bus.s_rdata), 128'(0));
        end
        clear_engine();
        #2 rst_n = 1'b1;

        // all masters requesting, zero-wait slave
        req_pct  = 100;
        lat_max  = 0;
        gapchk   = 1'b1;
        last_cmp = 0;
        step();
        step();
        chk("first_grant_after_reset", 128'({bus.busy, bus.grant_id}), 128'({1'b1, 2'd0}));
        repeat (40) step();
        gapchk = 1'b0;

        // random requests with short latencies and payload churn during BUSY
        req_pct = 50;
        lat_max = 5;
        repeat (300) step();

        // latencies that reach and exceed the timeout
        req_pct = 40;
        lat_max = 12;
        repeat (400) step();

        // asynchronous reset while a transaction is in flight
        found = 1'b0;
        for (int n = 0; n < 200 && !found; n++) begin
            step();
            if (bus.m_req) found = 1'b1;
        end
        chk("inflight_found", 128'(found), 128'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_m_req", 128'(bus.m_req), 128'(0));
        chk("async_rst_busy", 128'(bus.busy), 128'(0));
        chk("async_rst_s_ready", 128'(bus.s_ready), 128'(0));
        clear_engine();
        @(negedge clk);
        @(negedge clk);
        req_pct = 100;
        lat_max = 3;
        #3 rst_n = 1'b1;
        step();
        step();
        chk("grant_after_midflight_rst", 128'({bus.busy, bus.grant_id}), 128'({1'b1, 2'd0}));

        req_pct = 60;
        lat_max = 12;
        repeat (150) step();

        // drain outstanding requests
        req_pct = 0;
        found   = 1'b0;
        for (int n = 0; n < 400 && !found; n++) begin
            step();
            if (!bus.busy && !pend[0] && !pend[1] && !pend[2] && !pend[3]) found = 1'b1;
        end
        chk("drained", 128'(found), 128'(1));
        chk("queues_empty", 128'(bus_q.size() + rsp_q.size()), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sys_bus_arbiter.md
# sys_bus_arbiter

Round-robin arbiter that shares one system-bus master port among `NUM_MASTERS` per-core L1 arbiter master ports in the multicore CPU. It sits between the cores' L1 arbitration stage and the system bus / memory interconnect. It latches the winning request into a registered transaction and drives it on the bus until `m_ready`. It routes the response back to the owner and guards the bus with an optional response timeout.

## Interface
- `NUM_MASTERS`, 4: number of requesting ports, 2..8.
- `TIMEOUT_CYCLES`, 0: number of BUSY cycles without `m_ready` before a forced error completion. 0 disables the timeout. Range 0..65535.
- `clk` in 1: single clock, all logic on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `s_addr` in 32*N: per-master address; master i occupies bits [32i+31:32i].
- `s_wdata` in 32*N: per-master write data, same packing.
- `s_be` in 4*N: per-master byte enables.
- `s_we` in N: per-master write enable.
- `s_req` in N: per-master request, level-held until that master's `s_ready`.
- `s_rdata` out 32*N: per-master read data. Valid only while that master's `s_ready` is high; 0 otherwise.
- `s_ready` out N: per-master one-cycle completion pulse.
- `s_err` out N: per-master error flag (timeout). Only high together with `s_ready`.
- `m_addr`, `m_wdata` out 32: system-bus address and write data.
- `m_be` out 4: system-bus byte enables.
- `m_we` out 1: system-bus write enable.
- `m_req` out 1: system-bus request.
- `m_rdata` in 32: system-bus read data.
- `m_ready` in 1: system-bus completion. May be combinational from `m_req`.
- `grant_id` out clog2(N): index of the current owner. Valid while `busy`.
- `busy` out 1: a transaction is in flight.

## Operation
- States: IDLE, BUSY.
- Round-robin pointer `last`, clog2(N) bits, resets to N-1. This gives master 0 highest priority after reset.
- **IDLE**
  - If any `s_req` bit is set, select the first set bit scanning `last+1, last+2, …` modulo N.
  - Latch that master's addr/wdata/be/we into the transaction registers and set `grant_id` to the winner.
  - Clear the timeout counter and go to BUSY.
  - Otherwise stay in IDLE.
  - `m_ready` is ignored in IDLE.
- **BUSY**
  - `m_req`=1. `m_addr`/`m_wdata`/`m_be`/`m_we` come from the latched registers, not from live `s_*` inputs.
  - On `m_ready`=1:
    - `s_ready[grant_id]`=1 and the `grant_id` slice of `s_rdata` = `m_rdata`, combinationally in the same cycle.
    - `last` ← `grant_id`; go to IDLE.
  - Otherwise, with the timeout enabled, the counter increments each cycle.
  - Timeout: in the BUSY cycle where the counter equals `TIMEOUT_CYCLES` and `m_ready`=0:
    - `s_ready[grant_id]`=1, `s_err[grant_id]`=1, rdata slice=0.
    - `last` ← `grant_id`; go to IDLE.
  - If `m_ready`=1 in that same cycle, normal completion wins and `s_err`=0.
- The counter is 16 bits and saturates. It is not instantiated when `TIMEOUT_CYCLES`=0.
- A master dropping `s_req` mid-transaction does not abort it. The bus transaction completes and `s_ready` still pulses; the master ignores it.
- Changes on a granted master's `s_*` inputs during BUSY have no effect on the bus.
- Non-granted masters see `s_ready`=0, `s_err`=0 and `s_rdata`=0.
- Reset mid-transaction:
  - State returns to IDLE, `m_req` drops immediately (asynchronous), and `last` returns to N-1.
  - The in-flight request is abandoned. The bus slave is expected to be reset by the same `rst_n`.

## Timing
- Reset values:
  - state=IDLE, `last`=N-1, `busy`=0, `grant_id`=0.
  - `m_req`=0, `m_we`=0, `m_addr`=`m_wdata`=0, `m_be`=0.
  - All `s_ready`, `s_err` and `s_rdata` = 0.
- Arbitration latency is one cycle. A request sampled in IDLE at edge k gives `m_req`=1 during cycle k+1.
- Minimum transaction is 2 cycles (IDLE sample, BUSY with immediate `m_ready`).
- Back-to-back transactions have one IDLE cycle between completions. Maximum bus utilization is one transaction per 2 cycles with a zero-wait slave.
- `m_req`, the `m_*` payload, `busy` and `grant_id` are registered and glitch-free.
- `s_ready`, `s_err` and `s_rdata` are combinational from `m_ready`/`m_rdata` and state.
- Fairness: with all N masters requesting continuously, each is granted exactly once per N transactions.

## Test plan
- **Reset defaults:** hold `rst_n`=0 with random `s_req` -> all outputs 0, `m_req`=0. Release, then `s_req`=4'b1111 -> first grant is master 0.
- **Single read:** master 2 reads 0x0000_1000, slave returns 0xDEAD_BEEF with `m_ready` 3 cycles after `m_req` -> `m_addr`=0x1000, `m_we`=0. `s_ready[2]` pulses once with rdata 0xDEAD_BEEF; the other slices stay 0.
- **Round-robin:** `s_req`=4'b1111 held, zero-wait slave -> grant order 0,1,2,3,0,1… Completions occur every 2 cycles.
- **Payload isolation:** master 1 writes 0x1234_5678, be=4'b0011 to 0x40. `s_addr` slice is changed to 0x80 during BUSY -> the bus still shows 0x40/0x1234_5678/0011 until `m_ready`.
- **Timeout:** `TIMEOUT_CYCLES`=8, slave never responds -> `s_ready`+`s_err` for the owner after 9 BUSY cycles, rdata 0, then the next master is granted. Variant: `m_ready` arrives on the timeout cycle -> `s_err`=0.
- **Reset mid-flight:** assert `rst_n`=0 during BUSY -> `m_req` drops without waiting for a clock edge, state is IDLE, and the next grant goes to master 0.
